// File: rtl/phy_rx_symbol_decoder.sv
// PD PHY receive 4b5b decoder: ordered-set hunt, payload nibble decode, CRC-32 and timeout checks.
// Build option: define PHY_RX_SOP_TOLERANT_EN to accept SOP/SOP'/SOP'' on 3 of 4 matching symbols.
module phy_rx_symbol_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_NIBBLES    = 68
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_enable,
    input  logic       rx_clr,
    input  logic       rx_symbol_en,
    input  logic [4:0] rx_symbol,
    output logic       phy_control_rx_packet_en,
    output logic [2:0] phy_control_rx_packet_type,
    output logic       phy_control_rx_paylaod_en,
    output logic [3:0] phy_control_rx_paylaod,
    output logic       phy_control_rx_packet_eop,
    output logic       phy_control_rx_packet_crc_error,
    output logic       phy_control_rx_packet_payload_error,
    output logic       phy_control_rx_packet_timeout
);
    localparam int unsigned NW = $clog2(MAX_NIBBLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [4:0] SYM_S1  = 5'b11000;
    localparam logic [4:0] SYM_S2  = 5'b10001;
    localparam logic [4:0] SYM_S3  = 5'b00110;
    localparam logic [4:0] SYM_R1  = 5'b00111;
    localparam logic [4:0] SYM_R2  = 5'b11001;
    localparam logic [4:0] SYM_EOP = 5'b01101;

    // Oldest symbol sits in the top slice of each 20-bit pattern.
    localparam logic [19:0] OS_SOP   = {SYM_S1, SYM_S1, SYM_S1, SYM_S2};
    localparam logic [19:0] OS_SOP1  = {SYM_S1, SYM_S1, SYM_S3, SYM_S3};
    localparam logic [19:0] OS_SOP2  = {SYM_S1, SYM_S3, SYM_S1, SYM_S3};
    localparam logic [19:0] OS_HRST  = {SYM_R1, SYM_R1, SYM_R1, SYM_R2};
    localparam logic [19:0] OS_CRST  = {SYM_R1, SYM_S1, SYM_R1, SYM_S3};

    localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUAL = 32'hC704DD7B;

`ifdef PHY_RX_SOP_TOLERANT_EN
    localparam logic [2:0] SOP_MIN = 3'd3;
`else
    localparam logic [2:0] SOP_MIN = 3'd4;
`endif

    typedef enum logic {ST_HUNT, ST_PAYLOAD} state_t;

    function automatic logic [4:0] decode_data(input logic [4:0] s);
        case (s)
            5'b11110: decode_data = {1'b1, 4'h0};
            5'b01001: decode_data = {1'b1, 4'h1};
            5'b10100: decode_data = {1'b1, 4'h2};
            5'b10101: decode_data = {1'b1, 4'h3};
            5'b01010: decode_data = {1'b1, 4'h4};
            5'b01011: decode_data = {1'b1, 4'h5};
            5'b01110: decode_data = {1'b1, 4'h6};
            5'b01111: decode_data = {1'b1, 4'h7};
            5'b10010: decode_data = {1'b1, 4'h8};
            5'b10011: decode_data = {1'b1, 4'h9};
            5'b10110: decode_data = {1'b1, 4'hA};
            5'b10111: decode_data = {1'b1, 4'hB};
            5'b11010: decode_data = {1'b1, 4'hC};
            5'b11011: decode_data = {1'b1, 4'hD};
            5'b11100: decode_data = {1'b1, 4'hE};
            5'b11101: decode_data = {1'b1, 4'hF};
            default:  decode_data = '0;
        endcase
    endfunction

    function automatic logic [2:0] match_count(input logic [19:0] w, input logic [19:0] p);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w[5*i +: 5] == p[5*i +: 5]) n = n + 3'd1;
        end
        return n;
    endfunction

    // Left-shifting register with nibble bit 0 entering first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] n;
        n = c;
        for (int unsigned i = 0; i < 4; i++) begin
            if (n[31] ^ d[i]) n = {n[30:0], 1'b0} ^ CRC_POLY;
            else              n = {n[30:0], 1'b0};
        end
        return n;
    endfunction

    state_t          r_state;
    logic [14:0]     r_win;
    logic [31:0]     r_crc;
    logic [NW-1:0]   r_ncnt;
    logic [TW-1:0]   r_tcnt;
    logic            r_pkt_en;
    logic [2:0]      r_pkt_type;
    logic            r_pl_en;
    logic [3:0]      r_pl;
    logic            r_eop;
    logic            r_crc_err;
    logic            r_perr;
    logic            r_tmo;

    logic [19:0]     w_win;
    logic [4:0]      w_data;
    logic            w_os_hit;
    logic [2:0]      w_os_type;

    always_comb begin
        w_win     = {r_win, rx_symbol};
        w_data    = decode_data(rx_symbol);
        w_os_hit  = 1'b0;
        w_os_type = '0;
        if (match_count(w_win, OS_SOP) >= SOP_MIN) begin
            w_os_hit  = 1'b1;
            w_os_type = 3'd0;
        end else if (match_count(w_win, OS_SOP1) >= SOP_MIN) begin
            w_os_hit  = 1'b1;
            w_os_type = 3'd1;
        end else if (match_count(w_win, OS_SOP2) >= SOP_MIN) begin
            w_os_hit  = 1'b1;
            w_os_type = 3'd2;
        end else if (w_win == OS_HRST) begin
            w_os_hit  = 1'b1;
            w_os_type = 3'd3;
        end else if (w_win == OS_CRST) begin
            w_os_hit  = 1'b1;
            w_os_type = 3'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_HUNT;
            r_win      <= '0;
            r_crc      <= '0;
            r_ncnt     <= '0;
            r_tcnt     <= '0;
            r_pkt_en   <= 1'b0;
            r_pkt_type <= '0;
            r_pl_en    <= 1'b0;
            r_pl       <= '0;
            r_eop      <= 1'b0;
            r_crc_err  <= 1'b0;
            r_perr     <= 1'b0;
            r_tmo      <= 1'b0;
        end else begin
            r_pkt_en <= 1'b0;
            r_pl_en  <= 1'b0;
            r_eop    <= 1'b0;
            r_perr   <= 1'b0;
            r_tmo    <= 1'b0;
            if (rx_clr || !rx_enable) begin
                r_state <= ST_HUNT;
                r_win   <= '0;
                r_crc   <= '0;
                r_ncnt  <= '0;
                r_tcnt  <= '0;
                if (rx_clr) r_crc_err <= 1'b0;
            end else if (rx_symbol_en) begin
                r_tcnt <= '0;
                if (r_state == ST_HUNT) begin
                    if (w_os_hit) begin
                        r_pkt_en   <= 1'b1;
                        r_pkt_type <= w_os_type;
                        r_win      <= '0;
                        if (w_os_type < 3'd3) begin
                            r_crc_err <= 1'b0;
                            r_crc     <= '1;
                            r_ncnt    <= '0;
                            r_state   <= ST_PAYLOAD;
                        end
                    end else begin
                        r_win <= {r_win[9:0], rx_symbol};
                    end
                end else if (w_data[4]) begin
                    if (r_ncnt < NW'(MAX_NIBBLES)) begin
                        r_pl_en <= 1'b1;
                        r_pl    <= w_data[3:0];
                        r_crc   <= crc_step(r_crc, w_data[3:0]);
                        r_ncnt  <= r_ncnt + NW'(1);
                    end else begin
                        r_perr  <= 1'b1;
                        r_state <= ST_HUNT;
                    end
                end else if (rx_symbol == SYM_EOP && r_ncnt >= NW'(12) && !r_ncnt[0]) begin
                    r_eop     <= 1'b1;
                    r_crc_err <= (r_crc != CRC_RESIDUAL);
                    r_state   <= ST_HUNT;
                end else begin
                    r_perr  <= 1'b1;
                    r_state <= ST_HUNT;
                end
            end else if (r_state == ST_PAYLOAD) begin
                if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    r_tmo   <= 1'b1;
                    r_tcnt  <= '0;
                    r_state <= ST_HUNT;
                end else begin
                    r_tcnt <= r_tcnt + TW'(1);
                end
            end
        end
    end

    assign phy_control_rx_packet_en            = r_pkt_en;
    assign phy_control_rx_packet_type          = r_pkt_type;
    assign phy_control_rx_paylaod_en           = r_pl_en;
    assign phy_control_rx_paylaod              = r_pl;
    assign phy_control_rx_packet_eop           = r_eop;
    assign phy_control_rx_packet_crc_error     = r_crc_err;
    assign phy_control_rx_packet_payload_error = r_perr;
    assign phy_control_rx_packet_timeout       = r_tmo;

endmodule

// File: tb/tb_phy_rx_symbol_decoder.sv
// Directed, table-driven bench for phy_rx_symbol_decoder; expectations are hand-listed events per symbol.
`timescale 1ns/1ps
module tb_phy_rx_symbol_decoder;
    localparam int unsigned T    = 40;
    localparam int unsigned MAXN = 14;

    localparam int EV_NONE = 0;
    localparam int EV_PKT  = 1;
    localparam int EV_NIB  = 2;
    localparam int EV_EOP  = 3;
    localparam int EV_PERR = 4;
    localparam int EV_TMO  = 5;

    localparam logic [4:0] S1  = 5'b11000;
    localparam logic [4:0] S2  = 5'b10001;
    localparam logic [4:0] S3  = 5'b00110;
    localparam logic [4:0] R1  = 5'b00111;
    localparam logic [4:0] R2  = 5'b11001;
    localparam logic [4:0] EOP = 5'b01101;
    localparam logic [4:0] BAD = 5'b00000;
    localparam logic [4:0] DSYM [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                                         5'b01010, 5'b01011, 5'b01110, 5'b01111,
                                         5'b10010, 5'b10011, 5'b10110, 5'b10111,
                                         5'b11010, 5'b11011, 5'b11100, 5'b11101};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_enable = 1'b1;
    logic       rx_clr = 1'b0;
    logic       rx_symbol_en = 1'b0;
    logic [4:0] rx_symbol = '0;
    logic       pkt_en, pl_en, eop, crc_err, perr, tmo;
    logic [2:0] pkt_type;
    logic [3:0] pl;

    phy_rx_symbol_decoder #(.TIMEOUT_CYCLES(T), .MAX_NIBBLES(MAXN)) dut (
        .clk                                 (clk),
        .rst                                 (rst),
        .rx_enable                           (rx_enable),
        .rx_clr                              (rx_clr),
        .rx_symbol_en                        (rx_symbol_en),
        .rx_symbol                           (rx_symbol),
        .phy_control_rx_packet_en            (pkt_en),
        .phy_control_rx_packet_type          (pkt_type),
        .phy_control_rx_paylaod_en           (pl_en),
        .phy_control_rx_paylaod              (pl),
        .phy_control_rx_packet_eop           (eop),
        .phy_control_rx_packet_crc_error     (crc_err),
        .phy_control_rx_packet_payload_error (perr),
        .phy_control_rx_packet_timeout       (tmo)
    );

    always #5 clk = ~clk;

    // exp packs {pkt_en, pkt_type, pl_en, pl, eop, crc_err, perr, tmo}
    typedef struct {
        logic        clr;
        logic        sen;
        logic [4:0]  sym;
        logic [12:0] exp;
        int          tid;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   tid   = 0;
    bit   live  = 1'b0;
    logic [2:0] m_type = '0;
    logic [3:0] m_nib  = '0;
    logic       m_crc  = 1'b0;
    logic [3:0] crcn [8];

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] n;
        n = c;
        for (int i = 0; i < 4; i++) begin
            if (n[31] ^ d[i]) n = {n[30:0], 1'b0} ^ 32'h04C11DB7;
            else              n = {n[30:0], 1'b0};
        end
        return n;
    endfunction

    function automatic vec_t mk(input logic clr, input logic sen, input logic [4:0] sym,
                                input int ev, input logic [3:0] val);
        vec_t v;
        logic e_pe, e_pl, e_eop, e_perr, e_tmo;
        e_pe = 1'b0; e_pl = 1'b0; e_eop = 1'b0; e_perr = 1'b0; e_tmo = 1'b0;
        if (clr) m_crc = 1'b0;
        case (ev)
            EV_PKT:  begin e_pe = 1'b1; m_type = val[2:0]; if (val < 4'd3) m_crc = 1'b0; end
            EV_NIB:  begin e_pl = 1'b1; m_nib = val; end
            EV_EOP:  begin e_eop = 1'b1; m_crc = val[0]; end
            EV_PERR: e_perr = 1'b1;
            EV_TMO:  e_tmo = 1'b1;
            default: ;
        endcase
        v.clr = clr;
        v.sen = sen;
        v.sym = sym;
        v.exp = {e_pe, m_type, e_pl, m_nib, e_eop, m_crc, e_perr, e_tmo};
        v.tid = tid;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic [12:0] got;
        rx_clr       = v.clr;
        rx_symbol_en = v.sen;
        rx_symbol    = v.sym;
        @(posedge clk);
        #1;
        got = {pkt_en, pkt_type, pl_en, pl, eop, crc_err, perr, tmo};
        n_cmp++;
        if (got !== v.exp) begin
            n_err++;
            $display("FAIL test%0d step%0d: outputs got %b expected %b", v.tid, idx, got, v.exp);
        end
        rx_clr       = 1'b0;
        rx_symbol_en = 1'b0;
    endtask

    int step_no = 0;
    task automatic put(input vec_t v);
        if (live) begin
            run_vec(v, step_no);
            step_no++;
        end else begin
            vq.push_back(v);
        end
    endtask

    task automatic sym_none(input logic [4:0] s); put(mk(1'b0, 1'b1, s, EV_NONE, 4'd0)); endtask
    task automatic nib(input logic [3:0] n);      put(mk(1'b0, 1'b1, DSYM[n], EV_NIB, n)); endtask
    task automatic idle();                        put(mk(1'b0, 1'b0, BAD, EV_NONE, 4'd0)); endtask
    task automatic clr();                         put(mk(1'b1, 1'b0, BAD, EV_NONE, 4'd0)); endtask
    task automatic sop();
        sym_none(S1); sym_none(S1); sym_none(S1);
        put(mk(1'b0, 1'b1, S2, EV_PKT, 4'd0));
    endtask

    initial begin
        logic [31:0] c;
        logic [31:0] rv;
        logic [3:0]  hdr [4];
        hdr = '{4'h1, 4'h6, 4'h1, 4'h1};
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) c = crc_step(c, hdr[i]);
        for (int i = 0; i < 32; i++) rv[i] = ~c[31-i];
        for (int k = 0; k < 8; k++) crcn[k] = rv[4*k +: 4];

        // Good packet: header 0x1161 plus its CRC.
        tid = 1; sop();
        for (int i = 0; i < 4; i++) nib(hdr[i]);
        for (int k = 0; k < 8; k++) nib(crcn[k]);
        put(mk(1'b0, 1'b1, EOP, EV_EOP, 4'd0)); idle();
        // Corrupted second nibble: CRC error held past the eop.
        tid = 2; sop();
        nib(4'h1); nib(4'h7); nib(4'h1); nib(4'h1);
        for (int k = 0; k < 8; k++) nib(crcn[k]);
        put(mk(1'b0, 1'b1, EOP, EV_EOP, 4'd1)); idle(); idle();
        tid = 3; sym_none(R1); sym_none(R1); sym_none(R1);
        put(mk(1'b0, 1'b1, R2, EV_PKT, 4'd3)); sym_none(DSYM[5]); idle(); clr();
        tid = 4; sym_none(S1); sym_none(S1); sym_none(S3);
        put(mk(1'b0, 1'b1, S3, EV_PKT, 4'd1));
        put(mk(1'b0, 1'b1, EOP, EV_PERR, 4'd0)); clr();
        tid = 5; sym_none(S1); sym_none(S3); sym_none(S1);
        put(mk(1'b0, 1'b1, S3, EV_PKT, 4'd2)); clr();
        tid = 6; sym_none(R1); sym_none(S1); sym_none(R1);
        put(mk(1'b0, 1'b1, S3, EV_PKT, 4'd4)); sym_none(DSYM[2]); clr();
        tid = 7; sop(); nib(4'h2); nib(4'hA); nib(4'hF);
        put(mk(1'b0, 1'b1, BAD, EV_PERR, 4'd0)); sym_none(DSYM[3]); clr();
        tid = 8; sop(); for (int i = 0; i < 10; i++) nib(4'(i));
        put(mk(1'b0, 1'b1, EOP, EV_PERR, 4'd0)); clr();
        tid = 9; sop(); for (int i = 0; i < 13; i++) nib(4'(i));
        put(mk(1'b0, 1'b1, EOP, EV_PERR, 4'd0)); clr();
        tid = 10; sop(); for (int i = 0; i < 14; i++) nib(4'(i));
        put(mk(1'b0, 1'b1, DSYM[0], EV_PERR, 4'd0)); sym_none(DSYM[0]); clr();
        tid = 11; sym_none(S1); sym_none(S1); sym_none(R1);
`ifdef PHY_RX_SOP_TOLERANT_EN
        put(mk(1'b0, 1'b1, S2, EV_PKT, 4'd0));
`else
        sym_none(S2);
`endif
        clr();

        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({pkt_en, pkt_type, pl_en, pl, eop, crc_err, perr, tmo} !== 13'd0) begin
            n_err++;
            $display("FAIL reset: outputs got %b expected %b",
                     {pkt_en, pkt_type, pl_en, pl, eop, crc_err, perr, tmo}, 13'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

        live = 1'b1;
        // Timeout exactly T idle cycles after the last symbol.
        tid = 20; sop(); nib(4'h3); nib(4'h4); nib(4'h5); nib(4'h6);
        for (int k = 1; k < T; k++) idle();
        put(mk(1'b0, 1'b0, BAD, EV_TMO, 4'd0)); sym_none(DSYM[9]); clr();
        // rx_clr mid-packet: silent return to HUNT, no later timeout.
        tid = 21; sop(); nib(4'h2); nib(4'h2); clr();
        for (int k = 0; k < T + 2; k++) idle();
        sym_none(DSYM[1]); clr();
        // rx_enable low drops the packet.
        tid = 22; sop(); nib(4'h8);
        rx_enable = 1'b0; sym_none(DSYM[4]);
        rx_enable = 1'b1; sym_none(DSYM[4]); clr();
        // A symbol arriving on the expiry cycle wins over the timeout.
        tid = 23; sop(); nib(4'hA);
        for (int k = 1; k < T; k++) idle();
        nib(4'hB);
        for (int k = 1; k < T; k++) idle();
        put(mk(1'b0, 1'b0, BAD, EV_TMO, 4'd0)); clr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/phy_rx_symbol_decoder.md
# phy_rx_symbol_decoder

Receive-side 4b5b decode stage of the PD PHY, directly upstream of the PHY TX/RX control block. Takes aligned 5-bit symbols from the BMC bit-slicer, hunts for ordered sets (SOP/SOP'/SOP''/Hard Reset/Cable Reset), and decodes the payload into nibbles. Checks the running CRC-32 and flags EOP, payload errors and inter-symbol timeout on the `phy_control_rx_*` bus that the control block consumes.

## Interface
- `TIMEOUT_CYCLES`, 1000: max clk cycles between symbols in PAYLOAD before `timeout` fires.
- `MAX_NIBBLES`, 68: max decoded nibbles per packet (header + data + CRC).
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_enable`  in  1  1 = accept symbols. 0 = ignore `rx_symbol_en` and force HUNT.
- `rx_clr`  in  1  sync clear pulse. Returns to HUNT and clears `crc_error`.
- `rx_symbol_en`  in  1  symbol strobe, at most one per cycle.
- `rx_symbol`  in  5  received symbol, first-received bit in bit 0.
- `phy_control_rx_packet_en`  out  1  1-cycle pulse when an ordered set is recognised.
- `phy_control_rx_packet_type`  out  3  0 SOP, 1 SOP', 2 SOP'', 3 Hard Reset, 4 Cable Reset. Held until the next recognition.
- `phy_control_rx_paylaod_en`  out  1  1-cycle pulse per decoded nibble.
- `phy_control_rx_paylaod`  out  4  decoded nibble, held between pulses.
- `phy_control_rx_packet_eop`  out  1  1-cycle pulse on a valid EOP.
- `phy_control_rx_packet_crc_error`  out  1  level, valid from the EOP pulse until the next SOP, `rx_clr` or `rst`.
- `phy_control_rx_packet_payload_error`  out  1  1-cycle pulse.
- `phy_control_rx_packet_timeout`  out  1  1-cycle pulse.

## Operation
- Symbol codes:
  - Data 0..F: 11110, 01001, 10100, 10101, 01010, 01011, 01110, 01111, 10010, 10011, 10110, 10111, 11010, 11011, 11100, 11101.
  - Sync-1 11000, Sync-2 10001, Sync-3 00110, RST-1 00111, RST-2 11001, EOP 01101.
- Ordered sets, oldest symbol first:
  - SOP = S1 S1 S1 S2.
  - SOP' = S1 S1 S3 S3.
  - SOP'' = S1 S3 S1 S3.
  - HardReset = R1 R1 R1 R2.
  - CableReset = R1 S1 R1 S3.
- States: HUNT, PAYLOAD.
- HUNT:
  - A 4-symbol window shifts on each accepted symbol; the newest symbol is compared together with the previous three.
  - On a match, pulse `packet_en` and set `packet_type`.
  - Type 0-2: clear `crc_error`, set CRC = 0xFFFFFFFF and nibble count = 0, enter PAYLOAD.
  - Type 3-4: stay in HUNT and clear the window.
- PAYLOAD, on each symbol:
  - Data symbol:
    - Pulse `paylaod_en` with the nibble.
    - Advance the CRC by 4 bits: poly 0x04C11DB7, reflected, nibble bit 0 first.
    - Increment the nibble count.
  - EOP:
    - If count ≥ 12 and count is even: pulse `eop`, set `crc_error` = (CRC ≠ residual 0xC704DD7B).
    - Otherwise: pulse `payload_error`.
    - Either way, go to HUNT.
  - Any other symbol, or a data symbol that would make count > `MAX_NIBBLES`: pulse `payload_error`, go to HUNT, emit no nibble.
- Timeout counter:
  - Cleared on every accepted symbol and on entry to PAYLOAD; counts only in PAYLOAD.
  - At `TIMEOUT_CYCLES`: pulse `timeout`, go to HUNT.
- CRC nibbles are forwarded on `paylaod_en` like data; the downstream byte packer strips them.
- Priority: `rst` > `rx_clr` > `rx_enable`=0 > symbol processing > timeout.
  - If a symbol arrives in the same cycle the timeout expires, the symbol wins.
- On `rx_clr`, or when `rx_enable` goes low: go to HUNT, clear the window, CRC, nibble count and timeout counter. No pulse is emitted that cycle.

## Timing
- Every output is registered. Reset value of all outputs is 0, including `packet_type` = 0 and `paylaod` = 0. State is HUNT after reset.
- Latency is 1 cycle: a symbol accepted at edge N produces `packet_en`/`paylaod_en`/`eop`/`payload_error` after edge N+1.
- `crc_error` updates on the same edge as the `eop` pulse and stays stable for at least the following cycle, because the consumer samples it with a delayed `eop`.
- `timeout` is asserted on the edge where the counter reaches `TIMEOUT_CYCLES` idle cycles after the last symbol.
- Back-to-back symbols (`rx_symbol_en` every cycle) are fully supported; there is no backpressure.

## Configuration
- `PHY_RX_SOP_TOLERANT_EN` defined:
  - SOP, SOP' and SOP'' are recognised when at least 3 of the 4 window positions match. If several types qualify, the lowest type wins.
  - Hard Reset and Cable Reset still require an exact match.
- Undefined: every ordered set requires an exact 4-of-4 match.

## Test plan
- SOP, then header 0x1161 as nibbles 1,6,1,1 plus its correct CRC (8 nibbles, bench model), then EOP:
  - `packet_en` with type 0.
  - 12 `paylaod_en` pulses, first nibble 0x1.
  - `eop`, `crc_error`=0.
- Same packet with the 2nd nibble flipped to 0x7 -> `eop`, `crc_error`=1, held the following cycle.
- R1 R1 R1 R2 -> `packet_en` type 3, then no `paylaod_en` and state HUNT; a following data symbol produces no nibble.
- SOP, 3 data symbols, then 00000 -> 3 nibble pulses, then `payload_error` one cycle after 00000, back to HUNT.
- SOP, 4 data symbols, then no symbols -> `timeout` exactly `TIMEOUT_CYCLES` cycles after the last symbol. An `rx_clr` mid-packet instead gives no pulse and HUNT.
- S1 S1 R1 S2 -> type 0 `packet_en` with `PHY_RX_SOP_TOLERANT_EN` defined; no `packet_en` without it.
